mul4_fitness_scorer: RTL

Sequential fitness evaluator for evolved 4-word multiplier individuals. It drives a deterministic stream of pseudo-random operand vectors into one combinational `individual_*` candidate and compares the candidate's four 16-bit result words against a golden 32×32 product. It accumulates a bit-level score and a word-hit count per run. The block sits on both sides of the candidate: its stimulus outputs feed the candidate's inputs, and it consumes the candidate's outputs. It is the scoring stage the tournament harness reads after each run.

---
 rtl/mul4_eval_pkg.sv | 22 ++
 rtl/lfsr32.sv | 28 ++
 rtl/mul4_fitness_scorer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared types, constants and helpers for the 4-word multiplier fitness scorer.
package mul4_eval_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SCORE,
    ST_DONE
  } eval_state_t;

  localparam logic [31:0] LFSR32_MASK    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED_A = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_SEED_B = 32'h0000_0001;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n += 7'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR; reset and load both return it to the seed.
module lfsr32
  import mul4_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_d;

  always_comb begin
    q_d = q;
    if (load)      q_d = seed;
    else if (step) q_d = (q >> 1) ^ (q[0] ? LFSR32_MASK : 32'h0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) q <= seed;
    else     q <= q_d;
  end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Drives LFSR stimulus into a combinational candidate multiplier and scores its
// four result words against a golden 32x32 product, two cycles per vector.
module mul4_fitness_scorer
  import mul4_eval_pkg::*;
#(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED_A      = DEFAULT_SEED_A,
  parameter logic [31:0] SEED_B      = DEFAULT_SEED_B,
  localparam int         SW          = $clog2(64 * NUM_VECTORS + 1),
  localparam int         HW          = $clog2(4 * NUM_VECTORS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [15:0]   dut_a1,
  output logic [15:0]   dut_a0,
  output logic [15:0]   dut_b1,
  output logic [15:0]   dut_b0,
  input  logic [15:0]   dut_y3,
  input  logic [15:0]   dut_y2,
  input  logic [15:0]   dut_y1,
  input  logic [15:0]   dut_y0,
  output logic [SW-1:0] score,
  output logic [HW-1:0] word_hits
);

  localparam int KW = $clog2(NUM_VECTORS + 1);

  eval_state_t   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [63:0]   y_q, y_d, g_q, g_d;
  logic [SW-1:0] score_q, score_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [31:0]   lfsr_a, lfsr_b;
  logic          lfsr_load, lfsr_step;
  logic [2:0]    lane_hits;

  // The LFSRs run one vector ahead: they step in DRIVE so SCORE can copy the
  // next vector straight into the stimulus registers.
  lfsr32 u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_A),
    .step (lfsr_step),
    .q    (lfsr_a)
  );

  lfsr32 u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_B),
    .step (lfsr_step),
    .q    (lfsr_b)
  );

  always_comb begin
    lane_hits = '0;
    for (int i = 0; i < 4; i++)
      lane_hits += 3'(y_q[16*i +: 16] == g_q[16*i +: 16]);
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    a_d       = a_q;
    b_d       = b_q;
    y_d       = y_q;
    g_d       = g_q;
    score_d   = score_q;
    hits_d    = hits_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          a_d       = SEED_A;
          b_d       = SEED_B;
          score_d   = '0;
          hits_d    = '0;
          k_d       = '0;
          state_d   = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        y_d       = {dut_y3, dut_y2, dut_y1, dut_y0};
        g_d       = 64'(a_q) * 64'(b_q);
        lfsr_step = 1'b1;
        state_d   = ST_SCORE;
      end
      ST_SCORE: begin
        score_d = score_q + SW'(popcount64(~(y_q ^ g_q)));
        hits_d  = hits_q + HW'(lane_hits);
        a_d     = lfsr_a;
        b_d     = lfsr_b;
        if (k_q == KW'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      score_q <= '0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      score_q <= score_d;
      hits_q  <= hits_d;
    end
  end

  // NOTE: capture registers are always written in DRIVE before SCORE reads
  // them, so they carry no reset.
  always_ff @(posedge clk) begin
    y_q <= y_d;
    g_q <= g_d;
  end

  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SCORE);
  assign done      = (state_q == ST_DONE);
  assign {dut_a1, dut_a0} = a_q;
  assign {dut_b1, dut_b0} = b_q;
  assign score     = score_q;
  assign word_hits = hits_q;

endmodule
